// File: rtl/oh_7seg_pkg.sv
// Shared 7-segment constants: active-low segment patterns {a,b,c,d,e,f,g}, blank code
// and the capture FSM state encoding. The forward BCD->7-seg decoder uses the same patterns.
package oh_7seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HELD   = 1'b1;

endpackage

// File: rtl/oh_7seg_pattern2bcd.sv
// Inverse 7-segment table: maps an active-low pattern to its BCD digit.
// valid=1 for digits 0..9 and for the all-off blank pattern (is_blank=1, bcd=4'hF).
module oh_7seg_pattern2bcd
  import oh_7seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic       is_blank,
  output logic [3:0] bcd
);

  always_comb begin
    valid    = 1'b1;
    is_blank = 1'b0;
    bcd      = BCD_BLANK;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/oh_7seg_scan_capture.sv
// Captures a multiplexed active-low 7-segment bus back into per-digit BCD registers.
// Each stable {dig,seg} interval is evaluated exactly once; a full set of digits pulses frame.
module oh_7seg_scan_capture
  import oh_7seg_pkg::*;
#(
  parameter int N      = 4,
  parameter int STABLE = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [6:0]     seg,
  input  logic [N-1:0]   dig,
  output logic [4*N-1:0] bcd,
  output logic [N-1:0]   blank,
  output logic           upd,
  output logic [2:0]     upd_idx,
  output logic           seg_err,
  output logic           dig_err,
  output logic           frame
);

  localparam int CW = $clog2(STABLE + 1);

  logic [6:0]    seg_s1, seg_s, seg_p;
  logic [N-1:0]  dig_s1, dig_s, dig_p;
  logic [CW-1:0] cnt;
  logic [0:0]    state;
  logic [N-1:0]  seen;

  logic          same, eval, write;
  logic [3:0]    hot_cnt;
  logic [2:0]    hot_idx;
  logic [N-1:0]  seen_next;
  logic          dec_valid, dec_blank;
  logic [3:0]    dec_bcd;

  oh_7seg_pattern2bcd u_dec (
    .pattern  (seg_s),
    .valid    (dec_valid),
    .is_blank (dec_blank),
    .bcd      (dec_bcd)
  );

  // The interval is evaluated on the edge where the STABLE-th consecutive match is seen.
  assign same  = (dig_s == dig_p) && (seg_s == seg_p);
  assign eval  = same && (state == ST_SETTLE) && (cnt == CW'(STABLE - 1));
  assign write = eval && (hot_cnt == 4'd1) && dec_valid;

  always_comb begin
    hot_cnt   = 4'd0;
    hot_idx   = 3'd0;
    seen_next = seen;
    for (int i = 0; i < N; i++) begin
      if (dig_s[i]) begin
        hot_cnt = hot_cnt + 4'd1;
        hot_idx = 3'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (hot_idx == 3'(i)) seen_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1  <= SEG_BLANK;
      seg_s   <= SEG_BLANK;
      seg_p   <= SEG_BLANK;
      dig_s1  <= '0;
      dig_s   <= '0;
      dig_p   <= '0;
      cnt     <= '0;
      state   <= ST_SETTLE;
      seen    <= '0;
      bcd     <= {N{BCD_BLANK}};
      blank   <= '1;
      upd     <= 1'b0;
      upd_idx <= 3'd0;
      seg_err <= 1'b0;
      dig_err <= 1'b0;
      frame   <= 1'b0;
    end else begin
      seg_s1 <= seg;
      seg_s  <= seg_s1;
      dig_s1 <= dig;
      dig_s  <= dig_s1;
      seg_p  <= seg_s;
      dig_p  <= dig_s;

      if (same) begin
        if (cnt != CW'(STABLE)) cnt <= cnt + CW'(1);
      end else begin
        cnt   <= '0;
        state <= ST_SETTLE;
      end
      if (eval) state <= ST_HELD;

      upd     <= write;
      seg_err <= eval && (hot_cnt == 4'd1) && !dec_valid;
      dig_err <= eval && (hot_cnt > 4'd1);
      frame   <= 1'b0;

      if (write) begin
        upd_idx <= hot_idx;
        for (int i = 0; i < N; i++) begin
          if (hot_idx == 3'(i)) begin
            bcd[4*i +: 4] <= dec_bcd;
            blank[i]      <= dec_blank;
          end
        end
        // Completing the set clears the mask on the same edge so the next frame starts clean.
        if (&seen_next) begin
          frame <= 1'b1;
          seen  <= '0;
        end else begin
          seen  <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_oh_7seg_scan_capture.sv
// Bench for oh_7seg_scan_capture: directed scenarios plus random bus traffic, checked against
// an interval-level model that predicts one event per sufficiently long stable hold.
module tb_oh_7seg_scan_capture;

  localparam int N      = 4;
  localparam int STABLE = 3;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [6:0]     seg = 7'h7F;
  logic [N-1:0]   dig = '0;
  logic [4*N-1:0] bcd;
  logic [N-1:0]   blank;
  logic           upd, seg_err, dig_err, frame;
  logic [2:0]     upd_idx;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  oh_7seg_scan_capture #(.N(N), .STABLE(STABLE)) dut (
    .clk     (clk),
    .reset   (reset),
    .seg     (seg),
    .dig     (dig),
    .bcd     (bcd),
    .blank   (blank),
    .upd     (upd),
    .upd_idx (upd_idx),
    .seg_err (seg_err),
    .dig_err (dig_err),
    .frame   (frame)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Event word: {kind[1:0], idx[2:0], frame, bcd[15:0], blank[3:0]}; kind 1=upd 2=seg_err 3=dig_err
  logic [25:0]    exp_q[$];
  logic [6:0]     tbl[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
  logic [4*N-1:0] m_bcd;
  logic [N-1:0]   m_blank, m_seen;
  logic [N-1:0]   last_d;
  logic [6:0]     last_s;

  function automatic logic [25:0] mk(input logic [1:0] k, input logic [2:0] i, input logic f);
    return {k, i, f, m_bcd, m_blank};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_bcd   = '1;
    m_blank = '1;
    m_seen  = '0;
  endtask

  task automatic model_event(input logic [N-1:0] d, input logic [6:0] s, input int h);
    int idx, v;
    logic f;
    if (h < STABLE + 1 || d == '0) return;
    if ($countones(d) > 1) begin
      exp_q.push_back(mk(2'd3, 3'd0, 1'b0));
      return;
    end
    idx = 0;
    for (int i = 0; i < N; i++) if (d[i]) idx = i;
    v = -1;
    for (int j = 0; j < 10; j++) if (tbl[j] == s) v = j;
    if (v >= 0 || s == 7'h7F) begin
      m_bcd[4*idx +: 4] = (v >= 0) ? 4'(v) : 4'hF;
      m_blank[idx]      = (v < 0);
      m_seen[idx]       = 1'b1;
      f = &m_seen;
      if (f) m_seen = '0;
      exp_q.push_back(mk(2'd1, 3'(idx), f));
    end else begin
      exp_q.push_back(mk(2'd2, 3'd0, 1'b0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic hold(input logic [N-1:0] d, input logic [6:0] s, input int h);
    model_event(d, s, h);
    dig = d;
    seg = s;
    last_d = d;
    last_s = s;
    repeat (h) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cnt_upd = 0, cnt_serr = 0, cnt_derr = 0, cnt_frame = 0, last_upd_cyc = 0;
  logic [1:0]  mon_kind;
  logic [25:0] mon_obs, mon_exp;

  always @(negedge clk) begin
    if (!reset && (upd || seg_err || dig_err || frame)) begin
      case ({upd, seg_err, dig_err})
        3'b100:  mon_kind = 2'd1;
        3'b010:  mon_kind = 2'd2;
        3'b001:  mon_kind = 2'd3;
        default: mon_kind = 2'd0;
      endcase
      mon_obs = {mon_kind, upd ? upd_idx : 3'd0, frame, bcd, blank};
      if (upd) begin
        cnt_upd++;
        last_upd_cyc = cyc;
      end
      if (seg_err) cnt_serr++;
      if (dig_err) cnt_derr++;
      if (frame)   cnt_frame++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event_unexpected: got %h, none required (cycle %0d)", mon_obs, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          n_fail++;
          $display("FAIL event_match: got %h, required %h (cycle %0d)", mon_obs, mon_exp, cyc);
        end
      end
    end
  end

  task automatic do_reset();
    dig = '0;
    seg = 7'h7F;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_d = '0;
    last_s = 7'h7F;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int u0;
    do_reset();
    hold(4'b0001, 7'b0001111, 8);
    dig = 4'b0010;
    seg = 7'b0000110;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bcd !== 16'hFFFF || blank !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_regs: bcd=%h blank=%b, required FFFF/1111", bcd, blank);
    end
    n_checks++;
    if ({upd, seg_err, dig_err, frame, upd_idx} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: %b, required 0", {upd, seg_err, dig_err, frame, upd_idx});
    end
    u0 = cnt_upd;
    repeat (6) @(negedge clk);
    model_reset();
    dig = '0;
    seg = 7'h7F;
    @(negedge clk);
    reset = 1'b0;
    last_d = '0;
    last_s = 7'h7F;
    hold('0, 7'h7F, 20);
    n_checks++;
    if (cnt_upd !== u0 || exp_q.size() != 0 || bcd !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_quiet: upd %0d->%0d pending %0d bcd=%h, required no events, FFFF",
               u0, cnt_upd, exp_q.size(), bcd);
    end
  endtask

  task automatic test_scan();
    int f0;
    logic [6:0] pats[4] = '{7'b0010010, 7'b0000001, 7'b0010010, 7'b0100100};
    do_reset();
    f0 = cnt_frame;
    for (int i = 0; i < 4; i++) begin
      hold(4'(1 << i), pats[i], 8);
      hold('0, 7'h7F, 2);
    end
    hold('0, 7'h7F, 10);
    n_checks++;
    if (bcd !== 16'h5202 || blank !== 4'h0) begin
      n_fail++;
      $display("FAIL scan_bcd: bcd=%h blank=%b, required 5202/0000", bcd, blank);
    end
    n_checks++;
    if (cnt_frame - f0 != 1) begin
      n_fail++;
      $display("FAIL scan_frame: %0d frame pulses, required 1", cnt_frame - f0);
    end
  endtask

  task automatic test_glitch();
    int u0, t0;
    u0 = cnt_upd;
    hold(4'b0010, 7'b1001111, STABLE);
    hold('0, 7'h7F, 8);
    n_checks++;
    if (cnt_upd != u0) begin
      n_fail++;
      $display("FAIL glitch_short: %0d upd pulses, required 0", cnt_upd - u0);
    end
    t0 = cyc;
    hold(4'b0010, 7'b1001111, STABLE + 1);
    hold('0, 7'h7F, 8);
    n_checks++;
    if (cnt_upd - u0 != 1 || last_upd_cyc - t0 != STABLE + 3) begin
      n_fail++;
      $display("FAIL glitch_latency: %0d upd, latency %0d, required 1 upd latency %0d",
               cnt_upd - u0, last_upd_cyc - t0, STABLE + 3);
    end
    n_checks++;
    if (bcd[7:4] !== 4'd1) begin
      n_fail++;
      $display("FAIL glitch_value: bcd[1]=%h, required 1", bcd[7:4]);
    end
  endtask

  task automatic test_invalid();
    int s0, d0;
    logic [3:0] b0;
    s0 = cnt_serr;
    d0 = cnt_derr;
    b0 = bcd[3:0];
    hold(4'b0001, 7'b1111110, 10);
    hold(4'b0011, 7'b0000000, 10);
    hold('0, 7'h7F, 8);
    n_checks++;
    if (cnt_serr - s0 != 1 || bcd[3:0] !== b0) begin
      n_fail++;
      $display("FAIL invalid_seg: %0d seg_err, bcd[0]=%h, required 1 and %h", cnt_serr - s0,
               bcd[3:0], b0);
    end
    n_checks++;
    if (cnt_derr - d0 != 1) begin
      n_fail++;
      $display("FAIL invalid_dig: %0d dig_err, required 1", cnt_derr - d0);
    end
  endtask

  task automatic test_blank();
    hold(4'b1000, 7'h7F, 8);
    n_checks++;
    if (upd_idx !== 3'd3 || bcd[15:12] !== 4'hF || blank[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL blank_set: idx=%0d bcd[3]=%h blank[3]=%b, required 3/F/1", upd_idx,
               bcd[15:12], blank[3]);
    end
    hold(4'b1000, 7'b0001100, 8);
    n_checks++;
    if (bcd[15:12] !== 4'd9 || blank[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_clear: bcd[3]=%h blank[3]=%b, required 9/0", bcd[15:12], blank[3]);
    end
    hold('0, 7'h7F, 8);
  endtask

  task automatic test_exhaustive();
    int u0, s0;
    u0 = cnt_upd;
    s0 = cnt_serr;
    for (int p = 0; p < 128; p++) hold(4'b0001, 7'(p), STABLE + 2);
    hold('0, 7'h7F, 10);
    n_checks++;
    if (cnt_upd - u0 != 11 || cnt_serr - s0 != 117) begin
      n_fail++;
      $display("FAIL exhaustive_counts: upd %0d seg_err %0d, required 11/117", cnt_upd - u0,
               cnt_serr - s0);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d;
    logic [6:0]   s;
    int r;
    for (int k = 0; k < 250; k++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 2) d = '0;
        else if (r < 8) d = 4'(1 << $urandom_range(0, N - 1));
        else begin
          do d = 4'($urandom_range(0, 15)); while ($countones(d) < 2);
        end
        r = $urandom_range(0, 9);
        if (r < 5) s = tbl[$urandom_range(0, 9)];
        else if (r < 7) s = 7'h7F;
        else s = 7'($urandom_range(0, 127));
      end while (d == last_d && s == last_s);
      hold(d, s, $urandom_range(1, 8));
    end
    hold('0, 7'h7F, 12);
  endtask

  task automatic test_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d required events never seen", name, exp_q.size());
    end
  endtask

  initial begin
    model_reset();
    last_d = '0;
    last_s = 7'h7F;
    test_reset();
    test_scan();
    test_drained("scan");
    test_glitch();
    test_invalid();
    test_blank();
    test_drained("directed");
    test_exhaustive();
    test_drained("exhaustive");
    test_random();
    test_drained("random");
    n_checks++;
    if (bcd !== m_bcd || blank !== m_blank) begin
      n_fail++;
      $display("FAIL final_state: bcd=%h blank=%b, required %h/%b", bcd, blank, m_bcd, m_blank);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
